// File: rtl/upgrade_scheduler_if.sv
// Player positions and hit pulses into the upgrade scheduler, and the pickup
// position, visibility and per-player grant state coming back out.
interface upgrade_scheduler_if;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] Ball2X;
  logic [9:0] Ball2Y;
  logic       hit_1;
  logic       hit_2;
  logic [9:0] UpgradeX;
  logic [9:0] UpgradeY;
  logic       upgrade_visible;
  logic       bullet_1_upgraded;
  logic       bullet_2_upgraded;
  logic [7:0] hold_frames_left;

  modport master (
    output BallX, BallY, Ball2X, Ball2Y, hit_1, hit_2,
    input  UpgradeX, UpgradeY, upgrade_visible,
           bullet_1_upgraded, bullet_2_upgraded, hold_frames_left
  );

  modport slave (
    input  BallX, BallY, Ball2X, Ball2Y, hit_1, hit_2,
    output UpgradeX, UpgradeY, upgrade_visible,
           bullet_1_upgraded, bullet_2_upgraded, hold_frames_left
  );
endinterface

// File: rtl/upgrade_scheduler.sv
// Per-frame pickup lifecycle: cooldown, spawn at a rotating slot, collect or
// expire, then a timed single-holder grant that a hit on the holder revokes.
module upgrade_scheduler #(
  parameter int COOLDOWN_FRAMES = 120,
  parameter int LIFETIME_FRAMES = 300,
  parameter int DURATION_FRAMES = 240,
  parameter int UPGRADE_SIZE    = 8,
  parameter int X_BASE          = 80,
  parameter int X_STEP          = 64,
  parameter int Y_BASE          = 60,
  parameter int Y_STEP          = 40
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  upgrade_scheduler_if.slave   bus
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIFE_RELOAD = CNT_W'(LIFETIME_FRAMES - 1);
  localparam logic [7:0]       HOLD_LOAD   = 8'(DURATION_FRAMES);
  localparam logic [10:0]      SIZE_11     = 11'(UPGRADE_SIZE);

  typedef enum logic [1:0] {COOLDOWN, ACTIVE, HELD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       slot_q, slot_d;
  logic             tie_q, tie_d;      // 0: player 1 takes the next tie
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             vis_q, vis_d;
  logic             f1_q, f1_d;
  logic             f2_q, f2_d;
  logic [7:0]       hold_q, hold_d;

  logic o1, o2, win1, revoke;

  function automatic logic [9:0] slot_x(input logic [2:0] s);
    return 10'(X_BASE + int'(s) * X_STEP);
  endfunction

  function automatic logic [9:0] slot_y(input logic [2:0] s);
    return 10'(Y_BASE + ((int'(s) * 3) % 8) * Y_STEP);
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return (v < 0) ? 11'(-v) : 11'(v);
  endfunction

  // Zero-extend before subtracting so positions near 0 or 1023 never wrap.
  function automatic logic overlaps(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ux, input logic [9:0] uy);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    dx = $signed({1'b0, px}) - $signed({1'b0, ux});
    dy = $signed({1'b0, py}) - $signed({1'b0, uy});
    return (abs11(dx) <= SIZE_11) && (abs11(dy) <= SIZE_11);
  endfunction

  assign o1     = overlaps(bus.BallX,  bus.BallY,  x_q, y_q);
  assign o2     = overlaps(bus.Ball2X, bus.Ball2Y, x_q, y_q);
  assign win1   = o1 && (!o2 || !tie_q);
  assign revoke = (f1_q && bus.hit_1) || (f2_q && bus.hit_2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    tie_d   = tie_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    hold_d  = hold_q;
    unique case (state_q)
      COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
          vis_d   = 1'b1;
          cnt_d   = LIFE_RELOAD;
          x_d     = slot_x(slot_q);
          y_d     = slot_y(slot_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACTIVE: begin
        if (o1 || o2) begin
          if (o1 && o2) tie_d = ~tie_q;
          state_d = HELD;
          f1_d    = win1;
          f2_d    = ~win1;
          vis_d   = 1'b0;
          hold_d  = HOLD_LOAD;
          slot_d  = slot_q + 3'd1;
        end else if (cnt_q == '0) begin
          state_d = COOLDOWN;
          vis_d   = 1'b0;
          cnt_d   = COOL_RELOAD;
          slot_d  = slot_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HELD: begin
        // A revoke and the final grant frame end the same way.
        if (revoke || hold_q == 8'd1) begin
          state_d = COOLDOWN;
          f1_d    = 1'b0;
          f2_d    = 1'b0;
          hold_d  = 8'd0;
          cnt_d   = COOL_RELOAD;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = COOLDOWN;
        cnt_d   = COOL_RELOAD;
      end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= COOLDOWN;
      cnt_q   <= COOL_RELOAD;
      slot_q  <= 3'd0;
      tie_q   <= 1'b0;
      x_q     <= 10'(X_BASE);
      y_q     <= 10'(Y_BASE);
      vis_q   <= 1'b0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      tie_q   <= tie_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.UpgradeX          = x_q;
  assign bus.UpgradeY          = y_q;
  assign bus.upgrade_visible   = vis_q;
  assign bus.bullet_1_upgraded = f1_q;
  assign bus.bullet_2_upgraded = f2_q;
  assign bus.hold_frames_left  = hold_q;

endmodule

// File: tb/tb_upgrade_scheduler.sv
// Bench for upgrade_scheduler: directed lifecycle scenarios plus randomized
// frames, checked every edge against a phase/frames-remaining model.
module tb_upgrade_scheduler;
  localparam int COOL = 4, LIFE = 8, DUR = 6, SIZE = 8;
  localparam int XB = 80, XS = 64, YB = 60, YS = 40;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;

  upgrade_scheduler_if bus ();

  upgrade_scheduler #(
    .COOLDOWN_FRAMES(COOL), .LIFETIME_FRAMES(LIFE), .DURATION_FRAMES(DUR),
    .UPGRADE_SIZE(SIZE), .X_BASE(XB), .X_STEP(XS), .Y_BASE(YB), .Y_STEP(YS)
  ) dut (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting to spawn, 1 = pickup showing, 2 = granted.
  // m_left counts frames still to go in the current phase.
  int m_phase, m_left, m_slot, m_tie, m_holder, m_x, m_y;

  function automatic bit near(input int px, input int py);
    int dx, dy;
    dx = px - m_x;
    dy = py - m_y;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= SIZE) && (dy <= SIZE);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = COOL; m_slot = 0; m_tie = 1; m_holder = 0;
    m_x = XB; m_y = YB;
  endtask

  task automatic model_step();
    bit n1, n2;
    case (m_phase)
      0: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 1; m_left = LIFE;
          m_x = (XB + m_slot * XS) % 1024;
          m_y = (YB + ((m_slot * 3) % 8) * YS) % 1024;
        end
      end
      1: begin
        n1 = near(int'(bus.BallX), int'(bus.BallY));
        n2 = near(int'(bus.Ball2X), int'(bus.Ball2Y));
        if (n1 || n2) begin
          if (n1 && n2) begin
            m_holder = m_tie;
            m_tie = 3 - m_tie;
          end else begin
            m_holder = n1 ? 1 : 2;
          end
          m_phase = 2; m_left = DUR; m_slot = (m_slot + 1) % 8;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 0; m_left = COOL; m_slot = (m_slot + 1) % 8;
          end
        end
      end
      default: begin
        if ((m_holder == 1 && bus.hit_1 === 1'b1) || (m_holder == 2 && bus.hit_2 === 1'b1))
          m_left = 0;
        else
          m_left--;
        if (m_left == 0) begin
          m_phase = 0; m_left = COOL; m_holder = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("visible", bus.upgrade_visible, (m_phase == 1) ? 1 : 0);
    chk("upgrade_x", bus.UpgradeX, m_x);
    chk("upgrade_y", bus.UpgradeY, m_y);
    chk("flag_1", bus.bullet_1_upgraded, (m_holder == 1) ? 1 : 0);
    chk("flag_2", bus.bullet_2_upgraded, (m_holder == 2) ? 1 : 0);
    chk("hold_left", bus.hold_frames_left, (m_phase == 2) ? m_left : 0);
    chk("flags_exclusive", bus.bullet_1_upgraded & bus.bullet_2_upgraded, 0);
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic set_p(input int x1, input int y1, input int x2, input int y2);
    bus.BallX  = 10'(x1);
    bus.BallY  = 10'(y1);
    bus.Ball2X = 10'(x2);
    bus.Ball2Y = 10'(y2);
  endtask

  // Called just after an edge check; the drop lands mid-cycle, away from edges.
  task automatic assert_reset();
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  task automatic release_reset();
    @(negedge frame_clk);
    Reset_n = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask

  int wins[$];
  logic prev_vis;
  int r;

  initial begin
    bus.hit_1 = 1'b0;
    bus.hit_2 = 1'b0;
    set_p(0, 0, 0, 0);
    model_reset();
    @(posedge frame_clk);
    #1;
    compare_all();

    // Spawn timing, expiry and advance to slot 1.
    do_reset();
    set_p(0, 0, 0, 0);
    repeat (3) step();
    chk("a_pre_spawn", bus.upgrade_visible, 0);
    step();
    chk("a_spawn", bus.upgrade_visible, 1);
    chk("a_spawn_x", bus.UpgradeX, 80);
    chk("a_spawn_y", bus.UpgradeY, 60);
    repeat (7) step();
    chk("a_still_live", bus.upgrade_visible, 1);
    step();
    chk("a_expired", bus.upgrade_visible, 0);
    repeat (4) step();
    chk("a_slot1_vis", bus.upgrade_visible, 1);
    chk("a_slot1_x", bus.UpgradeX, 144);
    chk("a_slot1_y", bus.UpgradeY, 180);

    // Single collect by player 1 and a full-length grant.
    do_reset();
    set_p(86, 52, 0, 0);
    repeat (5) step();
    chk("b_flag", bus.bullet_1_upgraded, 1);
    chk("b_vis", bus.upgrade_visible, 0);
    chk("b_hold", bus.hold_frames_left, 6);
    repeat (5) step();
    chk("b_last_frame", bus.bullet_1_upgraded, 1);
    chk("b_hold_1", bus.hold_frames_left, 1);
    step();
    chk("b_grant_end", bus.bullet_1_upgraded, 0);
    chk("b_hold_0", bus.hold_frames_left, 0);

    // Both players on the pickup every cycle: ties alternate.
    do_reset();
    wins.delete();
    prev_vis = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_p(m_x, m_y, m_x + 3, m_y - 2);
      prev_vis = bus.upgrade_visible;
      step();
      if (prev_vis && bus.bullet_1_upgraded) wins.push_back(1);
      if (prev_vis && bus.bullet_2_upgraded) wins.push_back(2);
    end
    chk("c_tie_count_ok", (wins.size() >= 2) ? 1 : 0, 1);
    if (wins.size() >= 2) begin
      chk("c_tie_first", wins[0], 1);
      chk("c_tie_second", wins[1], 2);
    end

    // Player 2 holds; a hit on player 1 is ignored, a hit on player 2 revokes.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bit h1, h2;
      h1 = (m_phase == 2 && m_left == 5);
      h2 = (m_phase == 2 && m_left == 3);
      bus.hit_1 = h1;
      bus.hit_2 = h2;
      set_p(900, 900, m_x + 1, m_y + 1);
      step();
      if (h1) chk("d_hit1_ignored", bus.bullet_2_upgraded, 1);
      if (h2) begin
        chk("d_revoked_flag", bus.bullet_2_upgraded, 0);
        chk("d_revoked_hold", bus.hold_frames_left, 0);
      end
    end
    bus.hit_1 = 1'b0;
    bus.hit_2 = 1'b0;

    // Hit-box edges: one pixel outside, then exactly on the corner.
    do_reset();
    set_p(89, 60, 0, 0);
    repeat (12) step();
    chk("e_outside_noflag", bus.bullet_1_upgraded, 0);
    chk("e_outside_expired", bus.upgrade_visible, 0);
    do_reset();
    set_p(88, 68, 0, 0);
    repeat (5) step();
    chk("e_corner_flag", bus.bullet_1_upgraded, 1);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    set_p(80, 60, 0, 0);
    repeat (7) step();
    chk("f_hold_4", bus.hold_frames_left, 4);
    assert_reset();
    chk("f_async_flag", bus.bullet_1_upgraded, 0);
    chk("f_async_hold", bus.hold_frames_left, 0);
    release_reset();
    set_p(0, 0, 0, 0);
    repeat (4) step();
    chk("f_respawn_vis", bus.upgrade_visible, 1);
    chk("f_respawn_x", bus.UpgradeX, 80);
    chk("f_respawn_y", bus.UpgradeY, 60);

    // Randomized frames.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 3));
      bus.BallX  = 10'($urandom_range(0, 1023));
      bus.BallY  = 10'($urandom_range(0, 1023));
      bus.Ball2X = 10'($urandom_range(0, 1023));
      bus.Ball2Y = 10'($urandom_range(0, 1023));
      if (r == 1 || r == 3) begin
        bus.BallX = 10'(m_x + int'($urandom_range(0, 20)) - 10);
        bus.BallY = 10'(m_y + int'($urandom_range(0, 20)) - 10);
      end
      if (r == 2 || r == 3) begin
        bus.Ball2X = 10'(m_x + int'($urandom_range(0, 20)) - 10);
        bus.Ball2Y = 10'(m_y + int'($urandom_range(0, 20)) - 10);
      end
      bus.hit_1 = ($urandom_range(0, 7) == 0);
      bus.hit_2 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
